// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch controller between the PC and the instruction
//            ROM. Owns the PC, issues one ROM read at a time, waits a fixed
//            ROM latency, then holds the fetched word for decode under a
//            valid/ready handshake. A redirect loads a new (word-aligned) PC
//            and squashes any in-flight read.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC     PC loaded on reset (word-aligned)
//   ROM_LATENCY  cycles from ROM issue to rom_data_i valid, legal 1..7
// Ports
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   rom_en_o          ROM read strobe, high for the issue cycle only
//   rom_addr_o        byte address of the current fetch (PC)
//   rom_data_i        ROM read data, valid ROM_LATENCY cycles after issue
//   redirect_valid_i  load a new PC this cycle
//   redirect_pc_i     branch/jump target (byte address)
//   instr_valid_o     fetched instruction available
//   instr_ready_i     decode accepts the instruction
//   instr_o           fetched instruction word
//   instr_pc_o        PC of instr_o
//   fetch_count_o     completed handshakes        (FETCH_PERF_EN only)
//   stall_count_o     cycles valid && !ready       (FETCH_PERF_EN only)
// Build option
//   FETCH_PERF_EN     when defined, adds the two performance counters
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        rom_en_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [2:0] c_lat_init = 3'(ROM_LATENCY);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rom_en_q, rom_en_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        w_handshake;

  assign w_handshake = valid_q && instr_ready_i;

  // --------------------------------------------------------------------------
  // State register and all registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      rom_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      rom_en_q   <= rom_en_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = c_lat_init;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The counter reaches 1 in the cycle the ROM word is valid.
        if (cnt_q == 3'd1) begin
          instr_d    = rom_data_i;
          instr_pc_d = pc_q;
          state_d    = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HOLD: begin
        if (w_handshake) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A redirect overrides everything, including a same-cycle handshake's
    // PC+4. Any word arriving this cycle belongs to the abandoned fetch, so
    // the instruction registers keep their old contents.
    if (redirect_valid_i) begin
      pc_d       = redirect_pc_i & 32'hFFFF_FFFC;
      state_d    = ST_ISSUE;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end
  end

  // Strobe and valid are registered decodes of the next state so that no
  // input reaches an output combinationally.
  assign rom_en_d = (state_d == ST_ISSUE);
  assign valid_d  = (state_d == ST_HOLD);

  assign rom_en_o      = rom_en_q;
  assign rom_addr_o    = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

`ifdef FETCH_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32)
  // --------------------------------------------------------------------------
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (w_handshake) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (valid_q && !instr_ready_i) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule

`default_nettype wire
